prog_loader: RTL and testbench

- Upstream feeder for the processor's instruction memory; sits between a byte-stream source (UART receiver or bench) and the core.
- Assembles big-endian byte pairs into 16-bit instructions and writes them sequentially into INSMEM via we_ins/load/ins_addr.
- Holds the core in reset (cpu_reset) while no valid program is loaded, and releases it only after a load completes successfully.

---
 rtl/prog_loader.sv | 182 ++++++++++++++++++
 tb/tb_prog_loader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: byte-stream to instruction-memory loader; holds the core in
// reset until a complete program has been written.
// Stream: count byte N (1..DEPTH), then N big-endian 16-bit words.
// Ports:
//   clka, reset        clock, synchronous active-high reset
//   start              pulse, begins or restarts a load
//   byte_valid/data    incoming stream byte
//   byte_ready         loader accepts the byte this cycle
//   we_ins/load/ins_addr  instruction-memory write port
//   cpu_reset          high while the core must be held in reset
//   busy/done/err      status: loading, completion pulse, error flag
// Build option: PROG_LOADER_CHECKSUM_EN appends an XOR checksum byte.
module prog_loader #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clka,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              we_ins,
    output logic [15:0]       load,
    output logic [ADDR_W-1:0] ins_addr,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_COUNT,
        S_HI,
        S_LO,
        S_WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_FINISH,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       load_q, load_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              last;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]        xor_q, xor_d;
`endif

    assign last     = ({1'b0, addr_q} == (cnt_q - CNT_W'(1)));
    assign load     = load_q;
    assign ins_addr = addr_q;

    always_ff @(posedge clka) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            load_q  <= '0;
            addr_q  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            addr_q  <= addr_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_d     = load_q;
        addr_d     = addr_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        xor_d      = xor_q;
`endif
        byte_ready = 1'b0;
        we_ins     = 1'b0;
        done       = 1'b0;
        cpu_reset  = 1'b1;
        busy       = 1'b1;
        err        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_COUNT: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    if (byte_data == 8'd0 || int'(byte_data) > DEPTH) begin
                        state_d = S_ERROR;
                    end else begin
                        cnt_d   = CNT_W'(byte_data);
                        state_d = S_HI;
                    end
                end
            end
            S_HI: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    load_d[15:8] = byte_data;
`ifdef PROG_LOADER_CHECKSUM_EN
                    xor_d        = xor_q ^ byte_data;
`endif
                    state_d      = S_LO;
                end
            end
            S_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    load_d[7:0] = byte_data;
`ifdef PROG_LOADER_CHECKSUM_EN
                    xor_d       = xor_q ^ byte_data;
`endif
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                we_ins = 1'b1;
                if (last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_FINISH;
`endif
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_HI;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CSUM: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    state_d = (byte_data == xor_q) ? S_FINISH : S_ERROR;
                end
            end
`endif
            S_FINISH: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
                state_d   = S_DONE;
            end
            S_DONE: begin
                cpu_reset = 1'b0;
                busy      = 1'b0;
            end
            S_ERROR: begin
                err  = 1'b1;
                busy = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // start wins over any same-cycle byte: its effects are discarded.
        if (start) begin
            state_d = S_COUNT;
            addr_d  = '0;
            load_d  = load_q;
            cnt_d   = cnt_q;
`ifdef PROG_LOADER_CHECKSUM_EN
            xor_d   = '0;
`endif
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized scoreboard bench for prog_loader.
// Expected writes and done pulses are queued by the stimulus side.
module tb_prog_loader;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic              clka = 1'b0;
    logic              reset;
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              we_ins;
    logic [15:0]       load;
    logic [ADDR_W-1:0] ins_addr;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;
    bit stall_en = 1'b0;

    logic [21:0] exp_wr[$];
    int          exp_done = 0;

    prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clka       (clka),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .we_ins     (we_ins),
        .load       (load),
        .ins_addr   (ins_addr),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clka = ~clka;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes or finishes.
    always @(negedge clka) begin
        if (!reset) begin
            if (we_ins) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                             ins_addr, load);
                end else begin
                    check("write_addr_data", {10'd0, ins_addr, load},
                          {10'd0, exp_wr.pop_front()});
                end
                check("ready_low_in_write", byte_ready, 0);
                check("cpu_reset_in_write", cpu_reset, 1);
                check("done_not_with_write", done, 0);
            end
            if (done) begin
                if (exp_done == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected 0");
                end else begin
                    checks++;
                    exp_done--;
                end
                check("cpu_reset_at_done", cpu_reset, 0);
            end
        end
    end

    task automatic tick();
        @(negedge clka);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        if (stall_en) repeat ($urandom_range(0, 2)) tick();
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (!byte_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got byte_ready=0 expected 1");
        end
        tick();
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_wr.size() != 0 || exp_done != 0) && n < 50) begin
            tick();
            n++;
        end
        check("drain_pending", exp_wr.size() + exp_done, 0);
        tick();
    endtask

    // Reference: word i is bytes 2i+1/2i+2 of the stream at address i.
    task automatic load_prog(input int n, input bit good);
        logic [7:0] q[$];
        logic [7:0] x;
        logic [7:0] hi;
        logic [7:0] lo;
        x = 8'h00;
        q.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            hi = 8'($urandom);
            lo = 8'($urandom);
            q.push_back(hi);
            q.push_back(lo);
            x = x ^ hi ^ lo;
            exp_wr.push_back({6'(i), hi, lo});
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        q.push_back(good ? x : (x ^ 8'h5A));
`endif
        if (good) exp_done++;
        pulse_start();
        foreach (q[i]) send_byte(q[i]);
    endtask

    task automatic check_reset_vals();
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_we_ins", we_ins, 0);
        check("rst_load", load, 0);
        check("rst_ins_addr", ins_addr, 0);
        check("rst_byte_ready", byte_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) tick();
        check_reset_vals();
        reset = 1'b0;
        tick();

        // Fixed two-instruction load.
        exp_wr.push_back({6'd0, 16'h1234});
        exp_wr.push_back({6'd1, 16'hABCD});
        exp_done++;
        pulse_start();
        check("count_ready", byte_ready, 1);
        check("count_busy", busy, 1);
        check("count_cpu_reset", cpu_reset, 1);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hAB);
        send_byte(8'hCD);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h40);
`endif
        drain();
        check("done_cpu_reset", cpu_reset, 0);
        check("done_busy", busy, 0);
        check("done_err", err, 0);

        // Bad counts.
        pulse_start();
        send_byte(8'h00);
        check("zero_err", err, 1);
        check("zero_cpu_reset", cpu_reset, 1);
        check("zero_busy", busy, 0);
        check("zero_ready", byte_ready, 0);
        pulse_start();
        check("zero_err_clr", err, 0);
        send_byte(8'h41);
        check("big_err", err, 1);
        check("big_cpu_reset", cpu_reset, 1);
        pulse_start();
        check("big_err_clr", err, 0);

        // Full depth.
        load_prog(64, 1'b1);
        drain();
        check("full_last_addr", ins_addr, 63);
        check("full_cpu_reset", cpu_reset, 0);

        // Random loads with stalls.
        stall_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            load_prog($urandom_range(1, 8), 1'b1);
            drain();
        end
        stall_en = 1'b0;

        // Abort after three data bytes of a four-word load.
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        exp_wr.push_back({6'd0, b0, b1});
        pulse_start();
        send_byte(8'h04);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        check("abort_cpu_reset_pre", cpu_reset, 1);
        pulse_start();
        check("abort_cpu_reset_post", cpu_reset, 1);
        check("abort_addr", ins_addr, 0);
        exp_wr.push_back({6'd0, 16'hBEEF});
        exp_done++;
        send_byte(8'h01);
        send_byte(8'hBE);
        check("abort_cpu_reset_mid", cpu_reset, 1);
        send_byte(8'hEF);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h51);
`endif
        drain();
        check("abort_final_addr", ins_addr, 0);
        check("abort_cpu_released", cpu_reset, 0);

        // Reset while waiting for a high byte.
        pulse_start();
        send_byte(8'h02);
        check("hi_busy", busy, 1);
        reset = 1'b1;
        tick();
        check_reset_vals();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            byte_valid = 1'b1;
            byte_data  = 8'($urandom);
            tick();
            check("idle_ignore_ready", byte_ready, 0);
            check("idle_ignore_busy", busy, 0);
        end
        byte_valid = 1'b0;

`ifdef PROG_LOADER_CHECKSUM_EN
        load_prog(2, 1'b0);
        drain();
        check("csum_bad_err", err, 1);
        check("csum_bad_cpu_reset", cpu_reset, 1);
`endif

        load_prog(3, 1'b1);
        drain();
        check("final_err", err, 0);
        check("final_cpu_reset", cpu_reset, 0);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
